// File: rtl/cve2_alu_driver_if.sv
// Request/response handshake bundle between a requester and cve2_alu_driver.
// The requester uses the master modport; the driver uses the slave modport.
interface cve2_alu_driver_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [6:0]  req_op_i;
    logic [31:0] req_a_i;
    logic [31:0] req_b_i;
    logic        req_multicycle_i;
    logic        req_multdiv_i;

    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_result_o;
    logic [31:0] rsp_adder_o;
    logic        rsp_cmp_o;
    logic        rsp_eq_o;
    logic [2:0]  rsp_cycles_o;

    modport master (
        output req_valid_i, req_op_i, req_a_i, req_b_i, req_multicycle_i, req_multdiv_i,
        output rsp_ready_i,
        input  req_ready_o,
        input  rsp_valid_o, rsp_result_o, rsp_adder_o, rsp_cmp_o, rsp_eq_o, rsp_cycles_o
    );

    modport slave (
        input  req_valid_i, req_op_i, req_a_i, req_b_i, req_multicycle_i, req_multdiv_i,
        input  rsp_ready_i,
        output req_ready_o,
        output rsp_valid_o, rsp_result_o, rsp_adder_o, rsp_cmp_o, rsp_eq_o, rsp_cycles_o
    );
endinterface

// File: rtl/cve2_alu_driver.sv
// Active stimulus driver for the cve2 ALU: accepts op requests, drives the ALU inputs,
// feeds imd_val back and returns captured results. Optional adder check: CVE2_ALU_DRV_CHECK_EN.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | ready for a request; ALU inputs parked at ALU_ADD / zero
// S_EXEC | ALU driven from latched request; cyc counts EXEC cycles
// S_RESP | captured result presented until the response handshake
module cve2_alu_driver #(
    parameter int unsigned MULTI_CYCLES = 2,
    parameter int unsigned TXN_CNT_W    = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,

    cve2_alu_driver_if.slave     bus,

    output logic [6:0]           operator_o,
    output logic [31:0]          operand_a_o,
    output logic [31:0]          operand_b_o,
    output logic                 instr_first_cycle_o,
    output logic                 multdiv_sel_o,
    output logic [32:0]          multdiv_operand_a_o,
    output logic [32:0]          multdiv_operand_b_o,
    output logic [31:0]          imd_val_q_o [2],
    input  logic [31:0]          imd_val_d_i [2],
    input  logic [1:0]           imd_val_we_i,
    input  logic [31:0]          result_i,
    input  logic [31:0]          adder_result_i,
    input  logic                 comparison_result_i,
    input  logic                 is_equal_result_i,

    output logic [TXN_CNT_W-1:0] txn_count_o,
    output logic                 mismatch_o
);

    localparam logic [6:0] ALU_ADD  = 7'd0;
    localparam logic [6:0] ALU_SUB  = 7'd1;
    localparam logic [2:0] CYC_LAST = 3'(MULTI_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic        accept;
    logic        exec_done;
    logic        rsp_hs;
    logic        in_exec;

    logic [6:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic        mc_q;
    logic        md_q;
    logic [2:0]  cyc_q;
    logic [31:0] imd_q [2];

    logic [31:0] rsp_result_q;
    logic [31:0] rsp_adder_q;
    logic        rsp_cmp_q;
    logic        rsp_eq_q;
    logic [2:0]  rsp_cycles_q;

    logic [TXN_CNT_W-1:0] txn_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        exec_done = 1'b0;
        rsp_hs    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid_i) begin
                    accept  = 1'b1;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (!mc_q || (cyc_q == CYC_LAST)) begin
                    exec_done = 1'b1;
                    state_d   = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready_i) begin
                    rsp_hs  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            op_q  <= ALU_ADD;
            a_q   <= '0;
            b_q   <= '0;
            mc_q  <= 1'b0;
            md_q  <= 1'b0;
            cyc_q <= '0;
        end else if (accept) begin
            op_q  <= bus.req_op_i;
            a_q   <= bus.req_a_i;
            b_q   <= bus.req_b_i;
            mc_q  <= bus.req_multicycle_i;
            md_q  <= bus.req_multdiv_i;
            cyc_q <= '0;
        end else if (in_exec && !exec_done) begin
            cyc_q <= cyc_q + 3'd1;
        end
    end

    // A new request wipes any intermediate state left over from the previous op.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < 2; k++) imd_q[k] <= '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (accept) begin
                    imd_q[k] <= '0;
                end else if (in_exec && imd_val_we_i[k]) begin
                    imd_q[k] <= imd_val_d_i[k];
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rsp_result_q <= '0;
            rsp_adder_q  <= '0;
            rsp_cmp_q    <= 1'b0;
            rsp_eq_q     <= 1'b0;
            rsp_cycles_q <= '0;
        end else if (exec_done) begin
            rsp_result_q <= result_i;
            rsp_adder_q  <= adder_result_i;
            rsp_cmp_q    <= comparison_result_i;
            rsp_eq_q     <= is_equal_result_i;
            rsp_cycles_q <= cyc_q + 3'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            txn_q <= '0;
        end else if (rsp_hs) begin
            txn_q <= txn_q + TXN_CNT_W'(1);
        end
    end

    assign in_exec = (state_q == S_EXEC);

    assign bus.req_ready_o  = (state_q == S_IDLE);
    assign bus.rsp_valid_o  = (state_q == S_RESP);
    assign bus.rsp_result_o = rsp_result_q;
    assign bus.rsp_adder_o  = rsp_adder_q;
    assign bus.rsp_cmp_o    = rsp_cmp_q;
    assign bus.rsp_eq_o     = rsp_eq_q;
    assign bus.rsp_cycles_o = rsp_cycles_q;

    // ALU inputs are parked at ALU_ADD with zero operands whenever no op is executing.
    assign operator_o          = in_exec ? op_q : ALU_ADD;
    assign operand_a_o         = in_exec ? a_q : '0;
    assign operand_b_o         = in_exec ? b_q : '0;
    assign instr_first_cycle_o = in_exec && (cyc_q == 3'd0);
    assign multdiv_sel_o       = in_exec && md_q;
    assign multdiv_operand_a_o = in_exec ? {1'b0, a_q} : '0;
    assign multdiv_operand_b_o = in_exec ? {1'b0, b_q} : '0;
    assign imd_val_q_o[0]      = in_exec ? imd_q[0] : '0;
    assign imd_val_q_o[1]      = in_exec ? imd_q[1] : '0;

    assign txn_count_o = txn_q;

`ifdef CVE2_ALU_DRV_CHECK_EN
    logic [31:0] exp_adder;
    logic        chk_op;
    logic        mismatch_q;

    always_comb begin
        chk_op    = (op_q == ALU_ADD) || (op_q == ALU_SUB);
        exp_adder = (op_q == ALU_SUB) ? (a_q - b_q) : (a_q + b_q);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mismatch_q <= 1'b0;
        end else if (exec_done && chk_op && (adder_result_i != exp_adder)) begin
            mismatch_q <= 1'b1;
        end
    end

    assign mismatch_o = mismatch_q;
`else
    assign mismatch_o = 1'b0;
`endif

endmodule

// File: tb/tb_cve2_alu_driver.sv
// Directed bench for cve2_alu_driver (MULTI_CYCLES=3, TXN_CNT_W=2) with a tiny
// behavioural ALU; expected values are hand-computed constants.
module tb_cve2_alu_driver;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;

    logic [6:0]  operator_o;
    logic [31:0] operand_a_o, operand_b_o;
    logic        instr_first_cycle_o, multdiv_sel_o;
    logic [32:0] multdiv_operand_a_o, multdiv_operand_b_o;
    logic [31:0] imd_val_q_o [2];
    logic [31:0] imd_val_d_i [2];
    logic [1:0]  imd_val_we_i;
    logic [31:0] result_i, adder_result_i;
    logic        comparison_result_i, is_equal_result_i;
    logic [1:0]  txn_count_o;
    logic        mismatch_o;
    logic        bad_add;

    int n_cmp = 0;
    int n_err = 0;

    cve2_alu_driver_if bus ();

    cve2_alu_driver #(.MULTI_CYCLES(3), .TXN_CNT_W(2)) dut (
        .clk_i               (clk_i),
        .rst_i               (rst_i),
        .bus                 (bus),
        .operator_o          (operator_o),
        .operand_a_o         (operand_a_o),
        .operand_b_o         (operand_b_o),
        .instr_first_cycle_o (instr_first_cycle_o),
        .multdiv_sel_o       (multdiv_sel_o),
        .multdiv_operand_a_o (multdiv_operand_a_o),
        .multdiv_operand_b_o (multdiv_operand_b_o),
        .imd_val_q_o         (imd_val_q_o),
        .imd_val_d_i         (imd_val_d_i),
        .imd_val_we_i        (imd_val_we_i),
        .result_i            (result_i),
        .adder_result_i      (adder_result_i),
        .comparison_result_i (comparison_result_i),
        .is_equal_result_i   (is_equal_result_i),
        .txn_count_o         (txn_count_o),
        .mismatch_o          (mismatch_o)
    );

    always #5 clk_i = ~clk_i;

    // Minimal ALU: ADD/SUB adder, unsigned compare; bad_add corrupts the adder by +1.
    always_comb begin
        adder_result_i = ((operator_o == 7'd1) ? (operand_a_o - operand_b_o)
                                               : (operand_a_o + operand_b_o))
                         + {31'd0, bad_add};
        result_i            = adder_result_i;
        comparison_result_i = operand_a_o < operand_b_o;
        is_equal_result_i   = operand_a_o == operand_b_o;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic mid();
        @(negedge clk_i);
    endtask

    task automatic drive_req(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic mc, input logic md);
        bus.req_valid_i      = 1'b1;
        bus.req_op_i         = op;
        bus.req_a_i          = a;
        bus.req_b_i          = b;
        bus.req_multicycle_i = mc;
        bus.req_multdiv_i    = md;
    endtask

    logic exp_mis;

    initial begin
        bus.req_valid_i = 1'b0; bus.req_op_i = '0; bus.req_a_i = '0; bus.req_b_i = '0;
        bus.req_multicycle_i = 1'b0; bus.req_multdiv_i = 1'b0; bus.rsp_ready_i = 1'b1;
        imd_val_d_i[0] = '0; imd_val_d_i[1] = '0; imd_val_we_i = '0; bad_add = 1'b0;

        // Reset values
        tick(); tick();
        mid();
        chk("rst_req_ready", bus.req_ready_o, 1);
        chk("rst_rsp_valid", bus.rsp_valid_o, 0);
        chk("rst_operator", operator_o, 0);
        chk("rst_operand_a", operand_a_o, 0);
        chk("rst_imd0", imd_val_q_o[0], 0);
        chk("rst_txn", txn_count_o, 0);
        chk("rst_mismatch", mismatch_o, 0);
        chk("rst_first", instr_first_cycle_o, 0);
        tick(); rst_i = 1'b0;

        // ADD 5+3, single cycle
        tick(); drive_req(7'd0, 32'd5, 32'd3, 1'b0, 1'b0);
        tick(); bus.req_valid_i = 1'b0;
        mid();
        chk("add_exec_a", operand_a_o, 5);
        chk("add_exec_mdop_b", multdiv_operand_b_o, 33'd3);
        chk("add_exec_first", instr_first_cycle_o, 1);
        chk("add_exec_ready", bus.req_ready_o, 0);
        chk("add_exec_rspv", bus.rsp_valid_o, 0);
        tick(); mid();
        chk("add_rsp_valid", bus.rsp_valid_o, 1);
        chk("add_rsp_result", bus.rsp_result_o, 8);
        chk("add_rsp_cycles", bus.rsp_cycles_o, 1);
        chk("add_resp_op_parked", operand_a_o, 0);
        tick(); mid();
        chk("add_done_rspv", bus.rsp_valid_o, 0);
        chk("add_done_ready", bus.req_ready_o, 1);
        chk("add_txn", txn_count_o, 1);

        // SUB 0-1
        drive_req(7'd1, 32'd0, 32'd1, 1'b0, 1'b0);
        tick(); bus.req_valid_i = 1'b0;
        mid();
        chk("sub_exec_op", operator_o, 1);
        tick(); mid();
        chk("sub_rsp_result", bus.rsp_result_o, 32'hFFFF_FFFF);
        chk("sub_rsp_adder", bus.rsp_adder_o, 32'hFFFF_FFFF);
        chk("sub_rsp_cmp", bus.rsp_cmp_o, 1);
        chk("sub_rsp_eq", bus.rsp_eq_o, 0);
        chk("sub_mismatch", mismatch_o, 0);
        tick(); mid();
        chk("sub_txn", txn_count_o, 2);

        // Multi-cycle ADD 10+20 with multdiv and imd write in cycle 0; response stalled
        bus.rsp_ready_i = 1'b0;
        drive_req(7'd0, 32'd10, 32'd20, 1'b1, 1'b1);
        tick(); bus.req_valid_i = 1'b0;
        imd_val_we_i = 2'b01; imd_val_d_i[0] = 32'hDEAD_BEEF;
        mid();
        chk("mc_c0_first", instr_first_cycle_o, 1);
        chk("mc_c0_mdsel", multdiv_sel_o, 1);
        chk("mc_c0_mdop_a", multdiv_operand_a_o, 33'd10);
        chk("mc_c0_imd0", imd_val_q_o[0], 0);
        tick(); imd_val_we_i = 2'b00;
        mid();
        chk("mc_c1_imd0", imd_val_q_o[0], 32'hDEAD_BEEF);
        chk("mc_c1_imd1", imd_val_q_o[1], 0);
        chk("mc_c1_first", instr_first_cycle_o, 0);
        chk("mc_c1_rspv", bus.rsp_valid_o, 0);
        tick(); mid();
        chk("mc_c2_first", instr_first_cycle_o, 0);
        chk("mc_c2_rspv", bus.rsp_valid_o, 0);
        chk("mc_c2_imd0", imd_val_q_o[0], 32'hDEAD_BEEF);
        tick();
        drive_req(7'd0, 32'd1, 32'd1, 1'b0, 1'b0);
        mid();
        chk("mc_rsp_valid", bus.rsp_valid_o, 1);
        chk("mc_rsp_cycles", bus.rsp_cycles_o, 3);
        chk("mc_rsp_result", bus.rsp_result_o, 30);
        chk("mc_rsp_mdsel", multdiv_sel_o, 0);
        for (int i = 0; i < 5; i++) begin
            tick(); mid();
            chk("stall_rspv", bus.rsp_valid_o, 1);
            chk("stall_result", bus.rsp_result_o, 30);
            chk("stall_cycles", bus.rsp_cycles_o, 3);
            chk("stall_ready", bus.req_ready_o, 0);
            chk("stall_txn", txn_count_o, 2);
        end
        tick(); bus.rsp_ready_i = 1'b1;
        tick(); mid();
        chk("hs_idle_ready", bus.req_ready_o, 1);
        chk("hs_rspv", bus.rsp_valid_o, 0);
        chk("hs_txn", txn_count_o, 3);
        tick(); bus.req_valid_i = 1'b0;
        mid();
        chk("held_req_exec_a", operand_a_o, 1);
        tick(); mid();
        chk("held_req_result", bus.rsp_result_o, 2);
        chk("held_req_eq", bus.rsp_eq_o, 1);
        tick(); mid();
        chk("txn_wrap0", txn_count_o, 0);

        // Corrupted adder on ADD 0x1000+0x234
        drive_req(7'd0, 32'h1000, 32'h0234, 1'b0, 1'b0);
        bad_add = 1'b1;
        tick(); bus.req_valid_i = 1'b0;
        tick(); mid();
`ifdef CVE2_ALU_DRV_CHECK_EN
        exp_mis = 1'b1;
`else
        exp_mis = 1'b0;
`endif
        chk("bad_rsp_adder", bus.rsp_adder_o, 32'h1235);
        chk("bad_mismatch", mismatch_o, exp_mis);
        tick(); bad_add = 1'b0;
        mid();
        chk("txn_wrap1", txn_count_o, 1);
        chk("bad_mismatch_sticky", mismatch_o, exp_mis);

        // Reset in EXEC cycle 1 of a multi-cycle op
        drive_req(7'd1, 32'd7, 32'd2, 1'b1, 1'b1);
        tick(); bus.req_valid_i = 1'b0;
        tick(); rst_i = 1'b1;
        mid();
        chk("abort_ready", bus.req_ready_o, 1);
        chk("abort_rspv", bus.rsp_valid_o, 0);
        chk("abort_operator", operator_o, 0);
        chk("abort_operand_b", operand_b_o, 0);
        chk("abort_mdsel", multdiv_sel_o, 0);
        chk("abort_txn", txn_count_o, 0);
        chk("abort_mismatch", mismatch_o, 0);
        tick(); rst_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(); mid();
            chk("abort_no_rsp", bus.rsp_valid_o, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #50000;
        n_err++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog");
    end

endmodule
